// File: rtl/esp32_prog_sequencer.sv
// esp32_prog_sequencer
//   Sits between the FTDI modem-control lines and the ESP32 strap/enable pins.
//   The synchronized and glitch-filtered DTR/RTS pair is decoded into EN/GPIO0.
//   Each 11->10 auto-reset event opens a re-triggerable release window that
//   holds the boot strap. Between sequences the button word is shifted out on
//   the shared SPI MISO line.
//
// Parameters
//   C_RELEASE_BITS  release window length is 2^C_RELEASE_BITS cycles
//   C_FILTER        cycles (>=1) a synchronized DTR/RTS pair must be stable
//   C_BTN_WIDTH     width (>=2) of the button word
//
// Ports
//   clk_25MHz    in   sole clock
//   reset        in   synchronous, active-high
//   ftdi_ndtr    in   FTDI DTR (asynchronous)
//   ftdi_nrts    in   FTDI RTS (asynchronous)
//   mode         in   00 auto, 01 force run, 10 force flash, 11 hold in reset
//   btn_hold_n   in   low forces wifi_gpio0 low (except mode 11)
//   buttons      in   debounced button levels
//   spi_csn      in   OLED chip select from ESP32 (asynchronous)
//   spi_sclk     in   SPI clock from ESP32 (asynchronous)
//   wifi_en      out  ESP32 EN
//   wifi_gpio0   out  ESP32 GPIO0 strap
//   spi_miso     out  MISO data / GPIO2 strap value
//   spi_miso_oe  out  tristate enable for spi_miso
//   prog_active  out  release window active
//   prog_count   out  saturating count of auto-reset entries
module esp32_prog_sequencer #(
  parameter int C_RELEASE_BITS = 17,
  parameter int C_FILTER       = 4,
  parameter int C_BTN_WIDTH    = 8
) (
  input  logic                   clk_25MHz,
  input  logic                   reset,
  input  logic                   ftdi_ndtr,
  input  logic                   ftdi_nrts,
  input  logic [1:0]             mode,
  input  logic                   btn_hold_n,
  input  logic [C_BTN_WIDTH-1:0] buttons,
  input  logic                   spi_csn,
  input  logic                   spi_sclk,
  output logic                   wifi_en,
  output logic                   wifi_gpio0,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  output logic                   prog_active,
  output logic [7:0]             prog_count
);

  localparam int FW = $clog2(C_FILTER + 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  // synchronizers
  logic [1:0] r_dtr_s, r_rts_s, r_csn_s, r_sclk_s;
  logic       r_sclk_d;

  // filter
  logic [1:0]    r_pair_last, r_filt;
  logic [FW-1:0] r_stab;
  logic          r_trig;

  // FSM and outputs
  state_t                    r_state;
  logic [C_RELEASE_BITS-1:0] r_rel;
  logic [7:0]                r_count;
  logic                      r_en, r_io0, r_miso, r_oe, r_active;
  logic [C_BTN_WIDTH-1:0]    r_shreg;
  logic                      r_spi_blk;

  logic [1:0]                w_pair;
  logic                      w_chg, w_accept;
  logic [FW-1:0]             w_stab;
  state_t                    w_state_nxt;
  logic [C_RELEASE_BITS-1:0] w_rel_nxt;
  logic                      w_entry, w_active_nxt;
  logic                      w_en_nxt, w_io0_nxt;
  logic                      w_csn, w_rise, w_blk_nxt;
  logic [C_BTN_WIDTH-1:0]    w_shreg_nxt;
  logic                      w_miso_nxt, w_oe_nxt;

  assign w_pair = {r_dtr_s[1], r_rts_s[1]};
  assign w_csn  = r_csn_s[1];
  assign w_rise = r_sclk_s[1] & ~r_sclk_d;

  // w_stab counts the cycles the synchronized pair has held its current value,
  // including this one, so the accept lands C_FILTER cycles after it arrives.
  always_comb begin
    w_chg = (w_pair != r_pair_last);
    if (w_chg)
      w_stab = FW'(1);
    else if (r_stab == FW'(C_FILTER))
      w_stab = r_stab;
    else
      w_stab = r_stab + FW'(1);
    w_accept = (w_stab >= FW'(C_FILTER));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rel_nxt   = r_rel;
    w_entry     = 1'b0;
    if (mode != 2'b00) begin
      w_state_nxt = S_IDLE;
      w_rel_nxt   = '0;
    end else if (r_trig) begin
      // entry or re-trigger: restart the window
      w_state_nxt = S_HOLD;
      w_rel_nxt   = '0;
      w_entry     = 1'b1;
    end else if (r_state == S_HOLD) begin
      if (r_rel == {C_RELEASE_BITS{1'b1}}) begin
        w_state_nxt = S_IDLE;
        w_rel_nxt   = '0;
      end else begin
        w_rel_nxt = r_rel + C_RELEASE_BITS'(1);
      end
    end
    w_active_nxt = (w_state_nxt == S_HOLD);
  end

  always_comb begin
    unique case (mode)
      2'b00: begin
        unique case (r_filt)
          2'b10:   begin w_en_nxt = 1'b0; w_io0_nxt = 1'b1; end
          2'b01:   begin w_en_nxt = 1'b1; w_io0_nxt = 1'b0; end
          default: begin w_en_nxt = 1'b1; w_io0_nxt = 1'b1; end
        endcase
      end
      2'b01:   begin w_en_nxt = 1'b1; w_io0_nxt = 1'b1; end
      2'b10:   begin w_en_nxt = 1'b1; w_io0_nxt = 1'b0; end
      default: begin w_en_nxt = 1'b0; w_io0_nxt = 1'b1; end
    endcase
    if (mode != 2'b11)
      w_io0_nxt = w_io0_nxt & btn_hold_n;
  end

  // A window that opens while csn is low locks out shifting until csn has
  // gone high, so a half-shifted word is never resumed.
  always_comb begin
    w_blk_nxt = ~w_csn & (r_spi_blk | w_active_nxt);
    if (w_csn)
      w_shreg_nxt = buttons;
    else if (w_rise && !w_blk_nxt)
      w_shreg_nxt = {r_shreg[C_BTN_WIDTH-2:0], r_shreg[C_BTN_WIDTH-1]};
    else
      w_shreg_nxt = r_shreg;

    w_oe_nxt   = 1'b0;
    w_miso_nxt = 1'b0;
    if (w_active_nxt) begin
      w_oe_nxt   = 1'b1;
      w_miso_nxt = w_io0_nxt;
    end else if (!w_csn) begin
      w_oe_nxt   = 1'b1;
      w_miso_nxt = w_shreg_nxt[C_BTN_WIDTH-1];
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_dtr_s     <= 2'b11;
      r_rts_s     <= 2'b11;
      r_csn_s     <= 2'b11;
      r_sclk_s    <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_pair_last <= 2'b11;
      r_filt      <= 2'b11;
      r_stab      <= '0;
      r_trig      <= 1'b0;
      r_state     <= S_IDLE;
      r_rel       <= '0;
      r_count     <= 8'd0;
      r_en        <= 1'b1;
      r_io0       <= 1'b1;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_active    <= 1'b0;
      r_shreg     <= '0;
      r_spi_blk   <= 1'b0;
    end else begin
      r_dtr_s     <= {r_dtr_s[0], ftdi_ndtr};
      r_rts_s     <= {r_rts_s[0], ftdi_nrts};
      r_csn_s     <= {r_csn_s[0], spi_csn};
      r_sclk_s    <= {r_sclk_s[0], spi_sclk};
      r_sclk_d    <= r_sclk_s[1];
      r_pair_last <= w_pair;
      r_stab      <= w_stab;
      if (w_accept)
        r_filt <= w_pair;
      r_trig      <= w_accept && (r_filt == 2'b11) && (w_pair == 2'b10);
      r_state     <= w_state_nxt;
      r_rel       <= w_rel_nxt;
      if (w_entry && r_count != 8'hFF)
        r_count <= r_count + 8'd1;
      r_en        <= w_en_nxt;
      r_io0       <= w_io0_nxt;
      r_active    <= w_active_nxt;
      r_miso      <= w_miso_nxt;
      r_oe        <= w_oe_nxt;
      r_shreg     <= w_shreg_nxt;
      r_spi_blk   <= w_blk_nxt;
    end
  end

  assign wifi_en     = r_en;
  assign wifi_gpio0  = r_io0;
  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign prog_active = r_active;
  assign prog_count  = r_count;

endmodule

// File: doc/esp32_prog_sequencer.md
# esp32_prog_sequencer

Parametrised ESP32 programming sequencer and button readback port for the ULX3S passthru design. It sits between the FTDI modem-control lines and the ESP32 strap/enable pins, and decodes DTR/RTS into EN/GPIO0 through a glitch filter. After each auto-reset it holds the boot strap for a programmable release window. Between sequences it shifts a configurable-width button word out on the shared SD/OLED SPI lines. Relative to the fixed first generation, it adds the filter, a mode override, a re-triggerable release FSM, width-generic readback and an entry counter.

## Interface
Parameters:
- C_RELEASE_BITS, 17: release window lasts 2^C_RELEASE_BITS clock cycles.
- C_FILTER, 4: cycles (≥1) a DTR/RTS pair must be stable before it is accepted.
- C_BTN_WIDTH, 8: width (≥2) of the button word shifted out on MISO.

Ports:
- clk_25MHz  in  1  sole clock (25 MHz board oscillator).
- reset  in  1  synchronous, active-high.
- ftdi_ndtr  in  1  FTDI DTR, asynchronous.
- ftdi_nrts  in  1  FTDI RTS, asynchronous.
- mode  in  2  00 auto, 01 force run (EN=1, IO0=1), 10 force flash (EN=1, IO0=0), 11 hold ESP32 in reset (EN=0, IO0=1). Synchronous, quasi-static.
- btn_hold_n  in  1  low forces wifi_gpio0 low in every mode except 11.
- buttons  in  C_BTN_WIDTH  debounced button levels, synchronous.
- spi_csn  in  1  OLED chip select from the ESP32, asynchronous.
- spi_sclk  in  1  SPI clock from the ESP32, asynchronous.
- wifi_en  out  1  ESP32 EN.
- wifi_gpio0  out  1  ESP32 GPIO0 strap.
- spi_miso  out  1  MISO data / GPIO2 strap value.
- spi_miso_oe  out  1  tristate enable for spi_miso; the top level drives Z when this is 0.
- prog_active  out  1  release window active.
- prog_count  out  8  auto-reset entries, saturating.

## Operation
- ftdi_ndtr, ftdi_nrts, spi_csn and spi_sclk each pass a 2-FF synchronizer. The ndtr, nrts and csn synchronizers reset to 1; the sclk synchronizer resets to 0.
- Filter: a stability counter clears whenever the synchronized pair {dtr,rts} changes. The filtered pair takes the synchronized value once the counter reaches C_FILTER. The filtered pair resets to 11.
- Auto decode, filtered {dtr,rts} to {en,io0}:
  - 11 → 11
  - 00 → 11
  - 10 → 01
  - 01 → 10
- FSM states:
  - IDLE → HOLD: the filtered pair changes from 11 to 10 while mode=00. The release counter clears and prog_count increments, saturating at 255.
  - HOLD: the counter increments each cycle. A new 11→10 event restarts it at 0 and also increments prog_count. When the counter reaches 2^C_RELEASE_BITS−1, the FSM returns to IDLE on the next cycle.
  - mode≠00 forces IDLE immediately and clears the counter.
- prog_active = (state==HOLD).
- wifi_gpio0 = decoded or forced io0 AND btn_hold_n. In mode 11, wifi_gpio0 = 1.
- SPI readback:
  - While synchronized csn=1, the shift register loads buttons every cycle.
  - While csn=0, each detected sclk rising edge rotates it left by one. The MSB wraps to the LSB.
  - spi_miso = shreg[C_BTN_WIDTH−1].
- MISO mux, highest priority first:
  - prog_active=1: spi_miso_oe=1, spi_miso=wifi_gpio0 (GPIO2 strap follows IO0).
  - else csn=0: spi_miso_oe=1, spi_miso=shreg MSB.
  - else: spi_miso_oe=0.
- Reset values:
  - wifi_en=1, wifi_gpio0=1.
  - spi_miso=0, spi_miso_oe=0, prog_active=0, prog_count=0.
  - shift register 0, FSM IDLE.

## Timing
- All outputs are registered.
- DTR/RTS change to wifi_en/wifi_gpio0: 2 (sync) + C_FILTER + 1 cycles. A pulse shorter than C_FILTER cycles after synchronization produces no output change.
- prog_active rises on the same cycle that wifi_en falls for a qualifying event. It stays high for exactly 2^C_RELEASE_BITS cycles after the last trigger.
- Mode change: outputs follow 1 cycle after mode is sampled.
- btn_hold_n: affects wifi_gpio0 1 cycle after it is sampled.
- sclk rising edge to spi_miso update: 3 cycles.
- sclk high and low phases must each be ≥4 clk_25MHz cycles. The master samples MISO on the falling edge.
- The first bit (buttons MSB) is valid 3 cycles after csn falls.
- A csn rise mid-byte aborts the shift; the next cycle reloads buttons.
- A trigger while csn=0 gives the strap priority immediately; shifting resumes only after csn high then low.
- Reset during HOLD returns to IDLE with reset values on the next edge.

## Test plan
- Reset release with DTR=RTS=1, mode=00 → wifi_en=1, wifi_gpio0=1, spi_miso_oe=0, prog_count=0.
- Pair 11→10 held 20 cycles, with C_FILTER=4 and C_RELEASE_BITS=4 → wifi_en low 7 cycles after the pin change; prog_active high exactly 16 cycles; spi_miso_oe=1 and spi_miso=1 throughout; prog_count=1.
- Pair 11→10 pulse of 3 synchronized cycles → no output change, prog_count=0.
- Second 11→10 event 10 cycles into HOLD → window extends to 16 cycles after the second event; prog_count=2.
- buttons=8'hA5, csn low, 8 sclk pulses of 8/8 cycles → MISO bits 1,0,1,0,0,1,0,1; a 9th pulse outputs 1 (wrap).
- mode=11 with btn_hold_n=0 → wifi_en=0, wifi_gpio0=1. mode=10 → wifi_en=1, wifi_gpio0=0, prog_active=0.
